// File: rtl/led_ws2812_chain.sv
// -----------------------------------------------------------------------------
// led_ws2812_chain
//
// Serial driver for a WS2812-style neopixel chain. Colour words are fetched
// one LED at a time from an upstream LED store and shifted out as a single
// pulse-width-coded line. A 0 bit is high for 1 unit and low for 2 units. A 1
// bit is high for 2 units and low for 1 unit. One unit is nominally 400 ns.
// After the last LED the line is held low for the latch gap, and then a
// completion pulse is issued.
//
// Parameters
//   RESET_UNITS     latch gap length in 400 ns units (>= 1)
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   divider_400ns   clocks per unit minus 1; sampled at every unit reload
//   update          single-cycle refresh request, honoured only when idle
//   led_data_req    registered request for the colour word of led_number
//   led_number      index of the LED being requested
//   led_data_valid  upstream presents led_data / led_last
//   led_data        colour word {red, green, blue}
//   led_last        qualifies led_data: this LED ends the chain
//   led_chain       serial line, 1 = high
//   busy            high from update acceptance until done
//   done            single-cycle pulse at the end of the latch gap
// -----------------------------------------------------------------------------
module led_ws2812_chain #(
  parameter int unsigned RESET_UNITS = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  divider_400ns,
  input  logic        update,
  output logic        led_data_req,
  output logic [7:0]  led_number,
  input  logic        led_data_valid,
  input  logic [23:0] led_data,
  input  logic        led_last,
  output logic        led_chain,
  output logic        busy,
  output logic        done
);

  localparam int GAP_W = (RESET_UNITS > 1) ? $clog2(RESET_UNITS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RESET_UNITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e           state_q;
  logic [7:0]       cnt_q;        // unit counter, ticks at 0
  logic [7:0]       cnt_d;
  logic [1:0]       ph_q;         // unit within the current bit (0..2)
  logic [4:0]       bit_q;        // bit within the current LED (0..23)
  logic [23:0]      shift_q;      // wire-ordered word, MSB goes out first
  logic             last_q;       // LED being shifted ends the chain
  logic [23:0]      hold_q;       // prefetched next word (wire order)
  logic             hold_last_q;
  logic             hold_full_q;
  logic [GAP_W-1:0] gap_q;        // remaining latch-gap units minus 1
  logic             req_q;
  logic [7:0]       num_q;
  logic             chain_q;
  logic             busy_q;
  logic             done_q;

  logic             xfer;
  logic             unit_tick;
  logic             at_last;
  logic [23:0]      cap_word;

  // Wire order is green, red, blue, each MSB first.
  function automatic logic [23:0] wire_order(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  assign xfer      = req_q & led_data_valid;
  assign unit_tick = (cnt_q == 8'd0);
  // LED 255 is forced to be last so that led_number never wraps.
  assign at_last   = led_last | (num_q == 8'hFF);
  assign cap_word  = wire_order(led_data);

  // The unit counter only runs while the line is being timed. A transfer out
  // of FETCH restarts it so that the first bit is a full unit wide.
  always_comb begin
    cnt_d = cnt_q;
    unique case (state_q)
      S_FETCH: if (xfer) cnt_d = divider_400ns;
      S_SHIFT,
      S_GAP:   cnt_d = unit_tick ? divider_400ns : (cnt_q - 8'd1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ph_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      gap_q       <= '0;
      req_q       <= 1'b0;
      num_q       <= '0;
      chain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (update) begin
            state_q     <= S_FETCH;
            num_q       <= 8'd0;
            busy_q      <= 1'b1;
            req_q       <= 1'b1;
            hold_full_q <= 1'b0;
          end
        end

        S_FETCH: begin
          // Line stays low here, so a stall stretches the final low phase.
          if (xfer) begin
            req_q   <= 1'b0;
            shift_q <= cap_word;
            last_q  <= at_last;
            bit_q   <= 5'd0;
            ph_q    <= 2'd0;
            chain_q <= 1'b1;
            state_q <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (xfer) req_q <= 1'b0;

          // Prefetched word parks in the holding register unless it arrives
          // exactly on the final tick of bit 23, where it is used directly.
          if (xfer && !(unit_tick && ph_q == 2'd2 && bit_q == 5'd23)) begin
            hold_q      <= cap_word;
            hold_last_q <= at_last;
            hold_full_q <= 1'b1;
          end

          if (unit_tick) begin
            unique case (ph_q)
              2'd0: begin
                ph_q    <= 2'd1;
                chain_q <= shift_q[23];
              end
              2'd1: begin
                ph_q    <= 2'd2;
                chain_q <= 1'b0;
              end
              default: begin
                ph_q <= 2'd0;
                if (bit_q != 5'd23) begin
                  bit_q   <= bit_q + 5'd1;
                  shift_q <= {shift_q[22:0], 1'b0};
                  chain_q <= 1'b1;
                  // Entering bit 23: request the next LED early.
                  if (bit_q == 5'd22 && !last_q) begin
                    num_q <= num_q + 8'd1;
                    req_q <= 1'b1;
                  end
                end else if (last_q) begin
                  state_q <= S_GAP;
                  gap_q   <= GAP_LOAD;
                  chain_q <= 1'b0;
                end else if (hold_full_q) begin
                  shift_q     <= hold_q;
                  last_q      <= hold_last_q;
                  hold_full_q <= 1'b0;
                  bit_q       <= 5'd0;
                  chain_q     <= 1'b1;
                end else if (xfer) begin
                  shift_q <= cap_word;
                  last_q  <= at_last;
                  bit_q   <= 5'd0;
                  chain_q <= 1'b1;
                end else begin
                  // Data not here yet: wait in FETCH with req still high.
                  state_q <= S_FETCH;
                  chain_q <= 1'b0;
                end
              end
            endcase
          end
        end

        S_GAP: begin
          if (unit_tick) begin
            if (gap_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign led_data_req = req_q;
  assign led_number   = num_q;
  assign led_chain    = chain_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_led_ws2812_chain.sv
// -----------------------------------------------------------------------------
// tb_led_ws2812_chain
//
// Directed bench for led_ws2812_chain. A responder answers led_data_req from
// a per-LED data table (optionally stalling one LED). A line monitor records
// the high/low length of every bit, so that frames can be decoded and their
// timing checked against hand-computed words and lengths.
// -----------------------------------------------------------------------------
module tb_led_ws2812_chain;

  localparam int RESET_UNITS = 125;

  logic        clk;
  logic        reset_n;
  logic [7:0]  divider_400ns;
  logic        update;
  logic        led_data_req;
  logic [7:0]  led_number;
  logic        led_data_valid;
  logic [23:0] led_data;
  logic        led_last;
  logic        led_chain;
  logic        busy;
  logic        done;

  led_ws2812_chain #(.RESET_UNITS(RESET_UNITS)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .divider_400ns  (divider_400ns),
    .update         (update),
    .led_data_req   (led_data_req),
    .led_number     (led_number),
    .led_data_valid (led_data_valid),
    .led_data       (led_data),
    .led_last       (led_last),
    .led_chain      (led_chain),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Shared state between test, responder and monitor.
  int          clr_req = 0;
  logic        rsp_en = 1'b0;
  int          rsp_last_idx = 0;
  int          stall_led = -1;
  int          stall_len = 0;
  logic [23:0] rsp_data [256];
  logic [23:0] exp_w [256];
  int          xfer_idx [$];
  int          hq [$];
  int          lq [$];
  int          done_cnt = 0;

  typedef struct {
    logic [7:0]  div;
    logic [23:0] data;
    logic [23:0] exp_word;
    int          frame;     // clocks from first rise to the done cycle
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Responder: drives valid/data at negedges while enabled.
  initial begin
    int seen;
    int stall_cnt;
    seen = 0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (seen != clr_req) begin
        seen = clr_req;
        xfer_idx.delete();
        stall_cnt = 0;
      end
      if (rsp_en) begin
        led_data_valid = 1'b0;
        if (led_data_req === 1'b1) begin
          if (int'(led_number) == stall_led && stall_cnt < stall_len) begin
            stall_cnt++;
          end else begin
            led_data_valid = 1'b1;
            led_data       = rsp_data[led_number];
            led_last       = (int'(led_number) == rsp_last_idx);
            xfer_idx.push_back(int'(led_number));
          end
        end
      end
    end
  end

  // Line monitor: one (high, low) pair per bit; the last bit's low runs to done.
  initial begin
    int seen;
    int mh;
    int ml;
    bit in_bit;
    seen = 0; mh = 0; ml = 0; in_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (seen != clr_req) begin
        seen = clr_req;
        hq.delete();
        lq.delete();
        done_cnt = 0;
      end
      if (!reset_n) begin
        in_bit = 1'b0; mh = 0; ml = 0;
      end else begin
        if (done === 1'b1) begin
          done_cnt++;
          if (in_bit) begin hq.push_back(mh); lq.push_back(ml); end
          in_bit = 1'b0; mh = 0; ml = 0;
        end
        if (led_chain === 1'b1) begin
          if (in_bit && ml > 0) begin
            hq.push_back(mh); lq.push_back(ml); mh = 0; ml = 0;
          end
          in_bit = 1'b1;
          mh++;
        end else if (in_bit) begin
          ml++;
        end
      end
    end
  end

  task automatic clear_mon();
    clr_req++;
    @(negedge clk);
    @(negedge clk);
  endtask

  // update in cycle N -> busy/req in N+1; transfer in N+1 -> line high in N+2.
  task automatic start_frame(input string tag);
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk({tag, " busy N+1"}, busy, 1);
    chk({tag, " req N+1"}, led_data_req, 1);
    chk({tag, " number 0"}, led_number, 0);
    @(negedge clk);
    chk({tag, " rise after xfer"}, led_chain, 1);
    chk({tag, " req drop"}, led_data_req, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done seen"}, done, 1);
    chk({tag, " busy low at done"}, busy, 0);
    @(negedge clk);
    chk({tag, " done single"}, done, 0);
  endtask

  task automatic check_frame(input string tag, input int nleds, input int u,
                             input int xbit, input int xextra, input int exp_total);
    int bad;
    int total;
    int extra;
    logic [23:0] w;
    bad = 0;
    total = 0;
    chk({tag, " bit count"}, hq.size(), 24 * nleds);
    for (int i = 0; i < hq.size(); i++) begin
      extra = (i == xbit) ? xextra : 0;
      if (i == hq.size() - 1) extra += RESET_UNITS * u;
      if (!((hq[i] == u && lq[i] == 2 * u + extra) ||
            (hq[i] == 2 * u && lq[i] == u + extra))) bad++;
      total += hq[i] + lq[i];
    end
    chk({tag, " bit timing"}, bad, 0);
    chk({tag, " frame clocks"}, total, exp_total);
    for (int k = 0; k < nleds; k++) begin
      w = '0;
      for (int b = 0; b < 24; b++)
        if (24 * k + b < hq.size()) w[23 - b] = (hq[24 * k + b] == 2 * u);
      chk($sformatf("%s word %0d", tag, k), w, exp_w[k]);
    end
  endtask

  initial begin
    int n;
    int viol;
    int bad_idx;

    vecs[0] = '{8'd19, 24'hFF0000, 24'h00FF00, 3940};
    vecs[1] = '{8'd3,  24'h00FF00, 24'hFF0000, 788};
    vecs[2] = '{8'd1,  24'h0000A5, 24'h0000A5, 394};
    vecs[3] = '{8'd0,  24'h123456, 24'h341256, 197};
    vecs[4] = '{8'd7,  24'h5A3CC3, 24'h3C5AC3, 1576};

    // ---------------- reset with random inputs ----------------
    reset_n = 1'b0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      update         = 1'($urandom);
      led_data_valid = 1'($urandom);
      led_data       = 24'($urandom);
      led_last       = 1'($urandom);
      divider_400ns  = 8'($urandom);
      #1;
      if (led_chain !== 1'b0 || led_data_req !== 1'b0 || led_number !== 8'd0 ||
          busy !== 1'b0 || done !== 1'b0) viol++;
    end
    chk("reset outputs zero", viol, 0);
    @(negedge clk);
    update = 1'b0; led_data_valid = 1'b0; led_data = '0; led_last = 1'b0;
    divider_400ns = 8'd19;
    reset_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (led_chain !== 1'b0 || led_data_req !== 1'b0 || led_number !== 8'd0 ||
          busy !== 1'b0 || done !== 1'b0) viol++;
    end
    chk("idle outputs zero", viol, 0);
    rsp_en = 1'b1;

    // ---------------- single LED vectors ----------------
    for (int v = 0; v < 5; v++) begin
      divider_400ns = vecs[v].div;
      rsp_data[0]   = vecs[v].data;
      rsp_last_idx  = 0;
      exp_w[0]      = vecs[v].exp_word;
      clear_mon();
      start_frame($sformatf("vec%0d", v));
      wait_done($sformatf("vec%0d", v), 5000);
      check_frame($sformatf("vec%0d", v), 1, int'(vecs[v].div) + 1, -1, 0, vecs[v].frame);
      chk($sformatf("vec%0d xfers", v), xfer_idx.size(), 1);
    end

    // ---------------- three LEDs, back to back ----------------
    divider_400ns = 8'd19;
    rsp_data[0] = 24'h123456; exp_w[0] = 24'h341256;
    rsp_data[1] = 24'hA5C30F; exp_w[1] = 24'hC3A50F;
    rsp_data[2] = 24'h0F0F0F; exp_w[2] = 24'h0F0F0F;
    rsp_last_idx = 2;
    clear_mon();
    start_frame("three");
    wait_done("three", 8000);
    check_frame("three", 3, 20, -1, 0, 6820);
    chk("three xfers", xfer_idx.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < xfer_idx.size()) chk($sformatf("three number %0d", i), xfer_idx[i], i);

    // ---------------- stall on LED 1 ----------------
    // Request for LED 1 rises at the start of LED 0 bit 23 (60 clocks wide).
    // Valid held off for 159 request cycles -> transfer 100 clocks after the
    // normal bit boundary, so the final low of bit 23 is 100 clocks longer.
    rsp_data[0] = 24'h010203; exp_w[0] = 24'h020103;
    rsp_data[1] = 24'h808080; exp_w[1] = 24'h808080;
    rsp_last_idx = 1;
    stall_led = 1;
    stall_len = 159;
    clear_mon();
    start_frame("stall");
    wait_done("stall", 8000);
    check_frame("stall", 2, 20, 23, 100, 5480);
    chk("stall xfers", xfer_idx.size(), 2);
    stall_led = -1;
    stall_len = 0;

    // ---------------- update while busy ----------------
    divider_400ns = 8'd3;
    rsp_data[0] = 24'h00FF00; exp_w[0] = 24'hFF0000;
    rsp_last_idx = 0;
    clear_mon();
    start_frame("busy");
    repeat (100) @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk("busy still busy", busy, 1);
    wait_done("busy", 2000);
    repeat (1000) @(negedge clk);
    chk("busy done count", done_cnt, 1);
    chk("busy xfers", xfer_idx.size(), 1);
    chk("busy idle after", busy, 0);

    // ---------------- async reset during a high phase ----------------
    divider_400ns = 8'd0;
    rsp_data[0] = 24'h00FFFF;
    rsp_data[1] = 24'hFFFFFF;
    rsp_last_idx = 1;
    clear_mon();
    start_frame("rst");
    repeat (100) @(negedge clk);
    chk("rst reached LED 1", led_number, 1);
    n = 0;
    while (led_chain !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst in high phase", led_chain, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst chain low at once", led_chain, 0);
    chk("rst busy low", busy, 0);
    chk("rst req low", led_data_req, 0);
    chk("rst number zero", led_number, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_data[0] = 24'hFFFFFF; exp_w[0] = 24'hFFFFFF;
    rsp_last_idx = 0;
    clear_mon();
    start_frame("restart");
    wait_done("restart", 1000);
    check_frame("restart", 1, 1, -1, 0, 197);
    chk("restart xfers", xfer_idx.size(), 1);
    if (xfer_idx.size() > 0) chk("restart first number", xfer_idx[0], 0);

    // ---------------- max chain, never last ----------------
    divider_400ns = 8'd0;
    for (int i = 0; i < 256; i++) begin
      rsp_data[i] = {8'(i), ~8'(i), 8'h3C};
      exp_w[i]    = {~8'(i), 8'(i), 8'h3C};
    end
    rsp_last_idx = -1;
    clear_mon();
    start_frame("max");
    wait_done("max", 20000);
    check_frame("max", 256, 1, -1, 0, 18557);
    chk("max xfers", xfer_idx.size(), 256);
    bad_idx = 0;
    for (int i = 0; i < xfer_idx.size(); i++)
      if (xfer_idx[i] != i) bad_idx++;
    chk("max number sequence", bad_idx, 0);
    chk("max final number", led_number, 255);
    repeat (200) @(negedge clk);
    chk("max done count", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
